// File: rtl/clock_group_reset_sequencer.sv
// clock_group_reset_sequencer
// Fans one clock domain out to NUM_MEMBERS members: releases member resets in a
// staggered sequence after power-on, then services single-member re-reset
// requests through a req/ack handshake, lowest index first.
module clock_group_reset_sequencer #(
    parameter int unsigned NUM_MEMBERS = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned GAP_CYCLES  = 8,
    parameter int unsigned GAP_W       = $clog2(GAP_CYCLES + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_MEMBERS-1:0] member_rst_req,
    output logic [NUM_MEMBERS-1:0] member_rst_ack,
    output logic [NUM_MEMBERS-1:0] auto_out_member_reset,
    output logic [NUM_MEMBERS-1:0] auto_out_member_clock_en,
    output logic                   all_ready
);

    localparam int unsigned      IDX_W      = (NUM_MEMBERS > 1) ? $clog2(NUM_MEMBERS) : 1;
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_MEMBERS - 1);

    typedef enum logic [1:0] {
        HOLD,
        SEQ,
        RUN,
        MRST
    } state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     rst_sync;
    logic [GAP_W-1:0]         gap_q, gap_d;
    // idx doubles as the release pointer in SEQ and the member under re-reset in MRST
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [NUM_MEMBERS-1:0]   mrst_q, mrst_d;
    logic [NUM_MEMBERS-1:0]   clken_q, clken_d;
    logic [NUM_MEMBERS-1:0]   ack_q, ack_d;
    logic                     ready_q, ready_d;
    logic [NUM_MEMBERS-1:0]   pending;
    logic                     found;
    logic [IDX_W-1:0]         pick;

    function automatic logic [NUM_MEMBERS-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [NUM_MEMBERS-1:0] v;
        v = '0;
        for (int unsigned k = 0; k < NUM_MEMBERS; k++) begin
            if (IDX_W'(k) == i) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Reset synchroniser: asserts asynchronously, releases after SYNC_STAGES edges
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sync_q <= '0;
        else        sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end

    assign rst_sync = ~sync_q[SYNC_STAGES-1];

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= HOLD;
            gap_q   <= '0;
            idx_q   <= '0;
            mrst_q  <= '1;
            clken_q <= '0;
            ack_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            mrst_q  <= mrst_d;
            clken_q <= clken_d;
            ack_q   <= ack_d;
            ready_q <= ready_d;
        end
    end

    // Next-state and next-output logic; requests acked this cycle are masked
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        mrst_d  = mrst_q;
        clken_d = clken_q;
        ack_d   = '0;
        ready_d = ready_q;
        pending = member_rst_req & ~ack_q;
        found   = 1'b0;
        pick    = '0;
        for (int unsigned k = 0; k < NUM_MEMBERS; k++) begin
            if (pending[k] && !found) begin
                found = 1'b1;
                pick  = IDX_W'(k);
            end
        end
        case (state_q)
            HOLD: begin
                if (!rst_sync) begin
                    state_d = SEQ;
                    clken_d = '1;
                    idx_d   = '0;
                    gap_d   = GAP_RELOAD;
                end
            end
            SEQ: begin
                if (gap_q == '0) begin
                    mrst_d = mrst_q & ~onehot(idx_q);
                    gap_d  = GAP_RELOAD;
                    if (idx_q == LAST_IDX) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            RUN: begin
                if (found) begin
                    state_d = MRST;
                    idx_d   = pick;
                    mrst_d  = mrst_q | onehot(pick);
                    ready_d = 1'b0;
                    gap_d   = GAP_RELOAD;
                end
            end
            MRST: begin
                if (gap_q == '0) begin
                    mrst_d  = mrst_q & ~onehot(idx_q);
                    ack_d   = onehot(idx_q);
                    ready_d = 1'b1;
                    state_d = RUN;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: state_d = HOLD;
        endcase
    end

    assign member_rst_ack           = ack_q;
    assign auto_out_member_reset    = mrst_q;
    assign auto_out_member_clock_en = clken_q;
    assign all_ready                = ready_q;

endmodule
